// File: rtl/pipe_pe_ui_redacc.sv
// Framed reduction stage: sums a programmed number of unsigned differences from
// the subtract PE and holds the sum (with a sticky overflow flag) on a valid/ready port.
module pipe_pe_ui_redacc #(
    parameter int N     = 64,
    parameter int ACC_W = 80,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic [LEN_W-1:0] len,
    output logic             cts,
    input  logic             in_valid,
    input  logic [N-1:0]     in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [ACC_W-1:0] acc, acc_d;
    logic [LEN_W-1:0] cnt, cnt_d;
    logic             ovf_int, ovf_int_d;
    logic [ACC_W-1:0] out_d;
    logic             ovf_d;
    logic             out_valid_d;
    logic [ACC_W:0]   sum;

    // One extra bit holds the carry-out; the low ACC_W bits are the wrapped sum.
    function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                                 input logic [N-1:0]     b);
        return {1'b0, a} + (ACC_W+1)'(b);
    endfunction

    assign cts = (state == IDLE);

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        cnt_d       = cnt;
        ovf_int_d   = ovf_int;
        out_d       = out;
        ovf_d       = ovf;
        out_valid_d = out_valid;
        sum         = add_carry(acc, in);

        case (state)
            IDLE: begin
                if (trigger) begin
                    if (len != '0) begin
                        cnt_d     = len;
                        acc_d     = '0;
                        ovf_int_d = 1'b0;
                        state_d   = ACCUM;
                    end else begin
                        // Empty run: report a zero result immediately.
                        out_d       = '0;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d     = sum[ACC_W-1:0];
                    ovf_int_d = ovf_int | sum[ACC_W];
                    cnt_d     = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        out_d       = sum[ACC_W-1:0];
                        ovf_d       = ovf_int | sum[ACC_W];
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf_int   <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            ovf_int   <= ovf_int_d;
            out       <= out_d;
            ovf       <= ovf_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_pipe_pe_ui_redacc.sv
// Bench for pipe_pe_ui_redacc: an 80-bit and a 64-bit accumulator build share the
// same stimulus; expected results come from the exact run sum reduced to each width.
module tb_pipe_pe_ui_redacc;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic [15:0] len;
    logic        in_valid;
    logic [63:0] din;
    logic        out_ready;

    logic        cts_a, vld_a, ovf_a;
    logic [79:0] out_a;
    logic        cts_b, vld_b, ovf_b;
    logic [63:0] out_b;

    int checks   = 0;
    int failures = 0;

    logic [63:0] samp[$];
    int          gaps[$];

    always #5 clk = ~clk;

    pipe_pe_ui_redacc #(.N(64), .ACC_W(80), .LEN_W(16)) dut_a (
        .clk(clk), .rst(rst), .trigger(trigger), .len(len), .cts(cts_a),
        .in_valid(in_valid), .in(din), .out_valid(vld_a), .out_ready(out_ready),
        .out(out_a), .ovf(ovf_a)
    );

    pipe_pe_ui_redacc #(.N(64), .ACC_W(64), .LEN_W(16)) dut_b (
        .clk(clk), .rst(rst), .trigger(trigger), .len(len), .cts(cts_b),
        .in_valid(in_valid), .in(din), .out_valid(vld_b), .out_ready(out_ready),
        .out(out_b), .ovf(ovf_b)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Plays one frame: samples from samp, idle cycles before each from gaps,
    // then holds the result for hold_cyc cycles before accepting it.
    task automatic run_frame(input int hold_cyc);
        logic [127:0] total;
        logic [127:0] exp_a, exp_b;
        logic         eo_a, eo_b;
        int           n;
        n     = samp.size();
        total = '0;
        foreach (samp[i]) total = total + {64'd0, samp[i]};
        exp_a = {48'd0, total[79:0]};
        exp_b = {64'd0, total[63:0]};
        eo_a  = (total >> 80) != 0;
        eo_b  = (total >> 64) != 0;

        check_val("cts_before_trigger", {127'd0, cts_a & cts_b}, 128'd1);
        trigger  = 1'b1;
        len      = 16'(n);
        in_valid = 1'b0;
        tick();
        trigger = 1'b0;
        len     = 16'($urandom);

        if (n != 0) begin
            check_val("cts_in_accum", {126'd0, cts_a, cts_b}, 128'd0);
            for (int i = 0; i < n; i++) begin
                for (int g = 0; g < gaps[i]; g++) begin
                    in_valid = 1'b0;
                    din      = {$urandom, $urandom};
                    trigger  = 1'($urandom);
                    tick();
                    check_val("gap_no_valid", {124'd0, vld_a, vld_b, cts_a, cts_b}, 128'd0);
                end
                trigger  = 1'b0;
                in_valid = 1'b1;
                din      = samp[i];
                tick();
                if (i != n - 1)
                    check_val("mid_run_no_valid", {126'd0, vld_a, vld_b}, 128'd0);
            end
            in_valid = 1'b0;
        end

        check_val("out_valid_rise", {126'd0, vld_a, vld_b}, 128'd3);
        check_val("sum_80", {48'd0, out_a}, exp_a);
        check_val("ovf_80", {127'd0, ovf_a}, {127'd0, eo_a});
        check_val("sum_64", {64'd0, out_b}, exp_b);
        check_val("ovf_64", {127'd0, ovf_b}, {127'd0, eo_b});

        for (int h = 0; h < hold_cyc; h++) begin
            out_ready = 1'b0;
            trigger   = 1'($urandom);
            in_valid  = 1'($urandom);
            din       = {$urandom, $urandom};
            tick();
            check_val("hold_valid_cts", {124'd0, vld_a, vld_b, cts_a, cts_b}, 128'b1100);
            check_val("hold_sum_80", {48'd0, out_a}, exp_a);
            check_val("hold_sum_64", {64'd0, out_b}, exp_b);
            check_val("hold_ovf", {126'd0, ovf_a, ovf_b}, {126'd0, eo_a, eo_b});
        end

        out_ready = 1'b1;
        trigger   = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        trigger   = 1'b0;
        check_val("release_valid_cts", {124'd0, vld_a, vld_b, cts_a, cts_b}, 128'b0011);
        check_val("release_ovf_clr", {126'd0, ovf_a, ovf_b}, 128'd0);
        check_val("release_out_kept", {48'd0, out_a}, exp_a);
        tick();
        check_val("idle_after_release", {126'd0, cts_a, cts_b}, 128'd3);
    endtask

    task automatic set_gaps_zero;
        gaps.delete();
        foreach (samp[i]) gaps.push_back(0);
    endtask

    initial begin
        rst       = 1'b1;
        trigger   = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_val("reset_ctrl", {124'd0, cts_a, cts_b, vld_a, vld_b}, 128'b1100);
        check_val("reset_out", {48'd0, out_a}, 128'd0);
        check_val("reset_ovf", {126'd0, ovf_a, ovf_b}, 128'd0);

        // Basic four-sample run.
        samp = '{64'd10, 64'd20, 64'd30, 64'd40};
        set_gaps_zero();
        run_frame(0);

        // Gapped run: valid pattern 1,0,0,1,0,1.
        samp = '{64'd5, 64'd5, 64'd5};
        gaps = '{0, 2, 1};
        run_frame(0);

        // Backpressure for five cycles.
        samp = '{64'd123, 64'd456, 64'd789};
        set_gaps_zero();
        run_frame(5);

        // Carry out of the 64-bit build, then a clean run clears the flag.
        samp = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
        set_gaps_zero();
        run_frame(1);
        samp = '{64'd7};
        set_gaps_zero();
        run_frame(0);

        // Empty run.
        samp.delete();
        gaps.delete();
        run_frame(2);

        // Reset in the middle of a run.
        trigger = 1'b1;
        len     = 16'd4;
        tick();
        trigger  = 1'b0;
        in_valid = 1'b1;
        din      = 64'd100;
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst_mid_run_ctrl", {124'd0, cts_a, cts_b, vld_a, vld_b}, 128'b1100);
        check_val("rst_mid_run_out", {48'd0, out_a}, 128'd0);
        samp = '{64'd9};
        set_gaps_zero();
        run_frame(0);

        // Reset while a result is pending in HOLD.
        trigger = 1'b1;
        len     = 16'd0;
        tick();
        trigger = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst_in_hold", {124'd0, cts_a, cts_b, vld_a, vld_b}, 128'b1100);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(0, 6);
            samp.delete();
            gaps.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    samp.push_back(64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3)));
                else
                    samp.push_back({$urandom, $urandom});
                gaps.push_back(($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : 0);
            end
            run_frame($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
